// File: rtl/iterative_divide_unit.sv
// Multi-cycle restoring integer divider for RV32M/RV64M: one operation in flight,
// BITS_PER_CYCLE quotient bits per CALC cycle, tagged single-cycle completion pulse.
module iterative_divide_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int TAG_W          = 5
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    output logic             ready,
    output logic             busy,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic             is_signed,
    input  logic             div_type,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             done,
    output logic [XLEN-1:0]  wdata,
    output logic [TAG_W-1:0] tag_out
);

    localparam int N     = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state, next_state;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   dvsr, quo, rem;
    logic              neg_q, neg_r, sel_quo;
    logic [TAG_W-1:0]  tag_q;

    logic              accept, div_by_zero, overflow, special;
    logic              rs1_neg, rs2_neg;
    logic [XLEN-1:0]   rs1_mag, rs2_mag, special_result, fix_result;
    logic [XLEN-1:0]   quo_nxt, rem_nxt;
    logic [XLEN:0]     shifted, trial;

    assign accept      = start & ready & ~flush;
    assign rs1_neg     = is_signed & rs1_data[XLEN-1];
    assign rs2_neg     = is_signed & rs2_data[XLEN-1];
    assign rs1_mag     = rs1_neg ? -rs1_data : rs1_data;
    assign rs2_mag     = rs2_neg ? -rs2_data : rs2_data;
    assign div_by_zero = (rs2_data == '0);
    assign overflow    = is_signed & (rs1_data == MIN_INT) & (rs2_data == '1);
    assign special     = div_by_zero | overflow;

    always_comb begin
        special_result = '0;
        if (div_by_zero)
            special_result = div_type ? '1 : rs1_data;
        else if (overflow)
            special_result = div_type ? MIN_INT : '0;
    end

    // Quotient bits enter at the LSB of quo as the dividend bits shift out of its MSB.
    always_comb begin
        quo_nxt = quo;
        rem_nxt = rem;
        shifted = '0;
        trial   = '0;
        // NOTE: blocking assignments here are deliberate; each loop pass feeds the next
        // combinationally so one CALC cycle retires BITS_PER_CYCLE steps.
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            shifted = {rem_nxt, quo_nxt[XLEN-1]};
            trial   = shifted - {1'b0, dvsr};
            rem_nxt = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
            quo_nxt = {quo_nxt[XLEN-2:0], ~trial[XLEN]};
        end
    end

    assign fix_result = sel_quo ? (neg_q ? -quo : quo) : (neg_r ? -rem : rem);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: next_state = accept ? (special ? DONE : CALC) : IDLE;
                CALC:       if (cnt == CNT_W'(1)) next_state = FIX;
                FIX:        next_state = DONE;
                default:    next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        ready = (state == IDLE) | (state == DONE);
        busy  = (state == CALC) | (state == FIX);
        done  = (state == DONE);
    end

    // NOTE: every flop here is a plain register (no memory array), so all of them
    // take the asynchronous reset and outputs are defined straight out of reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt     <= '0;
            dvsr    <= '0;
            quo     <= '0;
            rem     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            sel_quo <= 1'b0;
            tag_q   <= '0;
            wdata   <= '0;
            tag_out <= '0;
        end else if (accept) begin
            quo     <= rs1_mag;
            rem     <= '0;
            dvsr    <= rs2_mag;
            neg_q   <= rs1_neg ^ rs2_neg;
            neg_r   <= rs1_neg;
            sel_quo <= div_type;
            tag_q   <= tag_in;
            cnt     <= special ? '0 : CNT_W'(N);
            if (special) begin
                wdata   <= special_result;
                tag_out <= tag_in;
            end
        end else if (!flush) begin
            if (state == CALC) begin
                quo <= quo_nxt;
                rem <= rem_nxt;
                cnt <= cnt - CNT_W'(1);
            end else if (state == FIX) begin
                wdata   <= fix_result;
                tag_out <= tag_q;
            end
        end
    end

endmodule

// File: tb/tb_iterative_divide_unit.sv
// Self-checking bench: three divider configurations against a latency/arithmetic
// reference model, plus directed vectors with hand-computed results.
module tb_iterative_divide_unit;

    localparam int TAG_W = 5;
    localparam int NDUT  = 3;

    logic             CLK = 1'b0;
    logic             nRST = 1'b0;
    logic             start = 1'b0;
    logic             flush = 1'b0;
    logic             is_signed = 1'b0;
    logic             div_type = 1'b0;
    logic [63:0]      a_bus = '0;
    logic [63:0]      b_bus = '0;
    logic [TAG_W-1:0] tag_bus = '0;
    int               sel = 0;
    bit               chk_en = 1'b0;

    int checks = 0;
    int errors = 0;

    logic             ready0, ready1, ready2, busy0, busy1, busy2, done0, done1, done2;
    logic [31:0]      wdata0, wdata1;
    logic [63:0]      wdata2;
    logic [TAG_W-1:0] tag0, tag1, tag2;

    logic             rdy_v [NDUT];
    logic             bsy_v [NDUT];
    logic             dn_v  [NDUT];
    logic [63:0]      wd_v  [NDUT];
    logic [TAG_W-1:0] tg_v  [NDUT];

    always #5 CLK = ~CLK;

    iterative_divide_unit #(.XLEN(32), .BITS_PER_CYCLE(1), .TAG_W(TAG_W)) u_dut0 (
        .CLK(CLK), .nRST(nRST), .start(start && sel == 0), .ready(ready0), .busy(busy0),
        .rs1_data(a_bus[31:0]), .rs2_data(b_bus[31:0]), .is_signed(is_signed),
        .div_type(div_type), .tag_in(tag_bus), .flush(flush), .done(done0),
        .wdata(wdata0), .tag_out(tag0));

    iterative_divide_unit #(.XLEN(32), .BITS_PER_CYCLE(4), .TAG_W(TAG_W)) u_dut1 (
        .CLK(CLK), .nRST(nRST), .start(start && sel == 1), .ready(ready1), .busy(busy1),
        .rs1_data(a_bus[31:0]), .rs2_data(b_bus[31:0]), .is_signed(is_signed),
        .div_type(div_type), .tag_in(tag_bus), .flush(flush), .done(done1),
        .wdata(wdata1), .tag_out(tag1));

    iterative_divide_unit #(.XLEN(64), .BITS_PER_CYCLE(2), .TAG_W(TAG_W)) u_dut2 (
        .CLK(CLK), .nRST(nRST), .start(start && sel == 2), .ready(ready2), .busy(busy2),
        .rs1_data(a_bus), .rs2_data(b_bus), .is_signed(is_signed),
        .div_type(div_type), .tag_in(tag_bus), .flush(flush), .done(done2),
        .wdata(wdata2), .tag_out(tag2));

    assign rdy_v[0] = ready0;  assign rdy_v[1] = ready1;  assign rdy_v[2] = ready2;
    assign bsy_v[0] = busy0;   assign bsy_v[1] = busy1;   assign bsy_v[2] = busy2;
    assign dn_v[0]  = done0;   assign dn_v[1]  = done1;   assign dn_v[2]  = done2;
    assign wd_v[0]  = {32'b0, wdata0};
    assign wd_v[1]  = {32'b0, wdata1};
    assign wd_v[2]  = wdata2;
    assign tg_v[0]  = tag0;    assign tg_v[1]  = tag1;    assign tg_v[2]  = tag2;

    function automatic int xlen_of(int k);
        return (k == 2) ? 64 : 32;
    endfunction

    function automatic int bpc_of(int k);
        return (k == 0) ? 1 : (k == 1) ? 4 : 2;
    endfunction

    function automatic logic [63:0] mask_of(int xlen);
        return (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic bit is_special(int xlen, logic [63:0] a_in, logic [63:0] b_in, bit sgn);
        logic [63:0] m, a, b;
        m = mask_of(xlen);
        a = a_in & m;
        b = b_in & m;
        return (b == 64'd0) || (sgn && a == (64'd1 << (xlen - 1)) && b == m);
    endfunction

    // RISC-V division semantics via plain 64-bit arithmetic.
    function automatic logic [63:0] ref_div(int xlen, logic [63:0] a_in, logic [63:0] b_in,
                                            bit sgn, bit typ);
        logic [63:0] m, a, b, min_v, q, r;
        longint      sa, sb;
        m     = mask_of(xlen);
        a     = a_in & m;
        b     = b_in & m;
        min_v = 64'd1 << (xlen - 1);
        if (b == 64'd0) return typ ? m : a;
        if (sgn && a == min_v && b == m) return typ ? min_v : 64'd0;
        if (sgn) begin
            sa = (xlen == 64) ? longint'(a) : longint'({{32{a[31]}}, a[31:0]});
            sb = (xlen == 64) ? longint'(b) : longint'({{32{b[31]}}, b[31:0]});
            q  = 64'(sa / sb);
            r  = 64'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return (typ ? q : r) & m;
    endfunction

    // Model state per DUT: cycles remaining until the done cycle (-1 = no operation).
    int               left      [NDUT] = '{-1, -1, -1};
    logic [63:0]      pend_data [NDUT] = '{64'd0, 64'd0, 64'd0};
    logic [TAG_W-1:0] pend_tag  [NDUT] = '{'0, '0, '0};
    logic [63:0]      exp_wdata [NDUT] = '{64'd0, 64'd0, 64'd0};
    logic [TAG_W-1:0] exp_tag   [NDUT] = '{'0, '0, '0};

    always @(posedge CLK or negedge nRST) begin
        int               nl;
        logic [63:0]      nd;
        logic [TAG_W-1:0] nt;
        for (int k = 0; k < NDUT; k++) begin
            if (!nRST) begin
                left[k]      <= -1;
                exp_wdata[k] <= '0;
                exp_tag[k]   <= '0;
            end else begin
                nl = (left[k] > 0) ? left[k] - 1 : -1;
                nd = pend_data[k];
                nt = pend_tag[k];
                if (flush) begin
                    nl = -1;
                end else if (start && sel == k && left[k] <= 0) begin
                    nd = ref_div(xlen_of(k), a_bus, b_bus, is_signed, div_type);
                    nt = tag_bus;
                    nl = is_special(xlen_of(k), a_bus, b_bus, is_signed) ? 0
                         : xlen_of(k) / bpc_of(k) + 1;
                end
                left[k]      <= nl;
                pend_data[k] <= nd;
                pend_tag[k]  <= nt;
                if (nl == 0) begin
                    exp_wdata[k] <= nd;
                    exp_tag[k]   <= nt;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            for (int k = 0; k < NDUT; k++) begin
                check($sformatf("ready[%0d]", k), 64'(rdy_v[k]), 64'(left[k] <= 0));
                check($sformatf("busy[%0d]", k),  64'(bsy_v[k]), 64'(left[k] > 0));
                check($sformatf("done[%0d]", k),  64'(dn_v[k]),  64'(left[k] == 0));
                check($sformatf("wdata[%0d]", k), wd_v[k], exp_wdata[k]);
                check($sformatf("tag[%0d]", k),   64'(tg_v[k]), 64'(exp_tag[k]));
            end
        end
    end

    // Drives one request for a cycle, then scrambles every operand input.
    task automatic issue(input int k, input logic [63:0] a, input logic [63:0] b,
                         input bit sgn, input bit typ, input logic [TAG_W-1:0] tg);
        sel       = k;
        a_bus     = a;
        b_bus     = b;
        is_signed = sgn;
        div_type  = typ;
        tag_bus   = tg;
        start     = 1'b1;
        @(posedge CLK);
        #1;
        start     = 1'b0;
        a_bus     = {$urandom, $urandom};
        b_bus     = {$urandom, $urandom};
        is_signed = 1'($urandom);
        div_type  = 1'($urandom);
        tag_bus   = TAG_W'($urandom);
    endtask

    task automatic wait_done(input int k, output int cycles);
        bit seen = 1'b0;
        cycles = 0;
        while (!seen && cycles < 100) begin
            @(negedge CLK);
            cycles++;
            if (dn_v[k]) seen = 1'b1;
        end
        check($sformatf("done_seen[%0d]", k), 64'(seen), 64'd1);
    endtask

    task automatic run_op(input int k, input logic [63:0] a, input logic [63:0] b,
                          input bit sgn, input bit typ, input logic [TAG_W-1:0] tg,
                          input logic [63:0] exp_data, input int exp_lat);
        int cyc;
        issue(k, a, b, sgn, typ, tg);
        wait_done(k, cyc);
        check($sformatf("latency[%0d]", k), 64'(cyc), 64'(exp_lat));
        check($sformatf("result[%0d]", k), wd_v[k], exp_data);
        check($sformatf("result_tag[%0d]", k), 64'(tg_v[k]), 64'(tg));
    endtask

    task automatic count_done(input int k, input int n_cyc, output int pulses);
        pulses = 0;
        repeat (n_cyc) begin
            @(negedge CLK);
            if (dn_v[k]) pulses++;
        end
    endtask

    initial begin
        int          cyc, pulses, k, xl;
        logic [63:0] a, b;

        @(posedge CLK);
        #1 chk_en = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_ready", 64'(ready0), 64'd1);
        check("rst_busy",  64'(busy0),  64'd0);
        check("rst_done",  64'(done0),  64'd0);
        check("rst_wdata", wd_v[0], 64'd0);
        nRST = 1'b1;

        // Signed -7 / 2 on the radix-2 unit.
        run_op(0, 64'hFFFF_FFF9, 64'd2, 1'b1, 1'b1, 5'd3, 64'hFFFF_FFFD, 34);
        run_op(0, 64'hFFFF_FFF9, 64'd2, 1'b1, 1'b0, 5'd3, 64'hFFFF_FFFF, 34);
        // Divide by zero and signed overflow complete the cycle after acceptance.
        run_op(0, 64'h1234, 64'd0, 1'b0, 1'b1, 5'd4, 64'hFFFF_FFFF, 1);
        run_op(0, 64'h1234, 64'd0, 1'b0, 1'b0, 5'd4, 64'h1234, 1);
        run_op(0, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1, 5'd5, 64'h8000_0000, 1);
        run_op(0, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b0, 5'd5, 64'd0, 1);
        // Four bits per cycle.
        run_op(1, 64'hFFFF_FFFF, 64'h10, 1'b0, 1'b1, 5'd6, 64'h0FFF_FFFF, 10);
        run_op(1, 64'hFFFF_FFFF, 64'h10, 1'b0, 1'b0, 5'd6, 64'hF, 10);
        // 64-bit operands.
        run_op(2, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, 1'b1, 5'd7, 64'hFFFF_FFFF_FFFF_FFF2, 34);
        run_op(2, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, 1'b0, 5'd7, 64'hFFFF_FFFF_FFFF_FFFE, 34);
        run_op(2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 5'd8,
               64'h8000_0000_0000_0000, 1);

        // Flush in c5 of a CALC: no completion, ready immediately after.
        issue(0, 64'd1000, 64'd3, 1'b0, 1'b1, 5'd9);
        repeat (4) @(posedge CLK);
        #1 flush = 1'b1;
        @(posedge CLK);
        #1 flush = 1'b0;
        check("flush_ready", 64'(ready0), 64'd1);
        check("flush_busy",  64'(busy0),  64'd0);
        count_done(0, 40, pulses);
        check("flush_no_done", 64'(pulses), 64'd0);

        // Flush and start together: the start is dropped.
        sel = 0; a_bus = 64'd50; b_bus = 64'd5; div_type = 1'b1; start = 1'b1; flush = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0; flush = 1'b0;
        check("flush_start_busy", 64'(busy0), 64'd0);
        count_done(0, 40, pulses);
        check("flush_start_no_done", 64'(pulses), 64'd0);

        // Flush during the DONE cycle keeps that cycle's pulse.
        issue(0, 64'd1000, 64'd3, 1'b0, 1'b1, 5'd14);
        repeat (33) @(posedge CLK);
        #1 flush = 1'b1;
        @(negedge CLK);
        check("flush_done_pulse", 64'(done0), 64'd1);
        check("flush_done_data", wd_v[0], 64'h14D);
        @(posedge CLK);
        #1 flush = 1'b0;
        check("flush_done_ready", 64'(ready0), 64'd1);

        // Back-to-back: second request accepted in the DONE cycle of the first.
        issue(0, 64'd100, 64'd7, 1'b0, 1'b1, 5'd10);
        wait_done(0, cyc);
        check("b2b_first", wd_v[0], 64'd14);
        check("b2b_first_tag", 64'(tag0), 64'd10);
        issue(0, 64'hFFFF_FF9C, 64'd7, 1'b1, 1'b0, 5'd11);
        wait_done(0, cyc);
        check("b2b_spacing", 64'(cyc), 64'd34);
        check("b2b_second", wd_v[0], 64'hFFFF_FFFE);
        check("b2b_second_tag", 64'(tag0), 64'd11);
        issue(1, 64'd5, 64'd0, 1'b0, 1'b1, 5'd12);
        wait_done(1, cyc);
        check("b2b_special_lat", 64'(cyc), 64'd1);
        check("b2b_special", wd_v[1], 64'hFFFF_FFFF);

        // Mixed regression; each issue lands in the previous DONE cycle where possible.
        for (int i = 0; i < 600; i++) begin
            k  = i % NDUT;
            xl = xlen_of(k);
            case ($urandom_range(0, 7))
                0:       b = 64'd0;
                1:       b = 64'hFFFF_FFFF_FFFF_FFFF;
                2, 3:    b = 64'($urandom_range(1, 16));
                default: b = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 5))
                0:       a = 64'd1 << (xl - 1);
                1:       a = 64'($urandom_range(0, 100));
                default: a = {$urandom, $urandom};
            endcase
            issue(k, a, b, 1'($urandom), 1'($urandom), TAG_W'($urandom));
            wait_done(k, cyc);
        end

        // Reset asserted mid-CALC.
        run_op(0, 64'd100, 64'd7, 1'b0, 1'b1, 5'd13, 64'd14, 34);
        issue(0, 64'd1000, 64'd3, 1'b0, 1'b1, 5'd15);
        repeat (5) @(posedge CLK);
        #1 nRST = 1'b0;
        #1;
        check("mid_rst_ready", 64'(ready0), 64'd1);
        check("mid_rst_busy",  64'(busy0),  64'd0);
        check("mid_rst_done",  64'(done0),  64'd0);
        check("mid_rst_wdata", wd_v[0], 64'd0);
        check("mid_rst_tag",   64'(tag0),   64'd0);
        @(negedge CLK);
        nRST = 1'b1;
        count_done(0, 40, pulses);
        check("mid_rst_no_done", 64'(pulses), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
